// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// WIDTH bits split into GROUP-bit lookahead groups, one pipeline stage per group.
// The carry is registered between stages. Operand and sum skew registers carry the
// partial result forward. A single global stall freezes every stage.
// Optional macro CLA_SAT_EN: on signed overflow the last stage saturates sum.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGES = WIDTH / GROUP;
    localparam int unsigned LAST    = NSTAGES - 1;

    // Group carries as sum-of-products of p/g and the group carry-in (no rippling).
    function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
        logic [GROUP:0] c;
        logic           term;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(GROUP); i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & c0);
        end
        return c;
    endfunction

    // Per-stage registers: valid, operands, partial sum, carry out of the stage.
    logic [NSTAGES-1:0]            v_q;
    logic [NSTAGES-1:0][WIDTH-1:0] a_q;
    logic [NSTAGES-1:0][WIDTH-1:0] b_q;
    logic [NSTAGES-1:0][WIDTH-1:0] s_q;
    logic [NSTAGES-1:0]            c_q;
    logic                          ovf_q;

    // Stage inputs (stage 0 reads the ports) and computed next values.
    logic [NSTAGES-1:0]            stage_v;
    logic [NSTAGES-1:0][WIDTH-1:0] stage_a;
    logic [NSTAGES-1:0][WIDTH-1:0] stage_b;
    logic [NSTAGES-1:0][WIDTH-1:0] stage_s;
    logic [NSTAGES-1:0]            stage_c;
    logic [NSTAGES-1:0][WIDTH-1:0] s_d;
    logic [NSTAGES-1:0]            c_d;
    logic [GROUP-1:0]              grp_p;
    logic [GROUP-1:0]              grp_g;
    logic [GROUP:0]                grp_c;
    logic                          cmsb;
    logic                          ovf_d;

    assign in_ready  = !out_valid || out_ready;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    // Stage inputs, per-group lookahead sums and the final overflow/saturation.
    always_comb begin
        stage_v = '0;
        stage_a = '0;
        stage_b = '0;
        stage_s = '0;
        stage_c = '0;
        s_d     = '0;
        c_d     = '0;
        grp_p   = '0;
        grp_g   = '0;
        grp_c   = '0;
        cmsb    = 1'b0;

        stage_v[0] = in_valid;
        stage_a[0] = a;
        stage_b[0] = sub ? ~b : b;
        stage_c[0] = sub ? 1'b1 : cin;
        for (int k = 1; k < int'(NSTAGES); k++) begin
            stage_v[k] = v_q[k-1];
            stage_a[k] = a_q[k-1];
            stage_b[k] = b_q[k-1];
            stage_s[k] = s_q[k-1];
            stage_c[k] = c_q[k-1];
        end

        for (int k = 0; k < int'(NSTAGES); k++) begin
            grp_p  = stage_a[k][k*GROUP +: GROUP] ^ stage_b[k][k*GROUP +: GROUP];
            grp_g  = stage_a[k][k*GROUP +: GROUP] & stage_b[k][k*GROUP +: GROUP];
            grp_c  = lookahead(grp_p, grp_g, stage_c[k]);
            s_d[k] = stage_s[k];
            s_d[k][k*GROUP +: GROUP] = grp_p ^ grp_c[GROUP-1:0];
            c_d[k] = grp_c[GROUP];
            if (k == int'(LAST)) begin
                cmsb = grp_c[GROUP-1];
            end
        end

        ovf_d = cmsb ^ c_d[LAST];
`ifdef CLA_SAT_EN
        if (ovf_d) begin
            s_d[LAST] = stage_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Operands of the final stage are not needed downstream.
    logic unused_skew;
    assign unused_skew = ^{a_q[LAST], b_q[LAST]};

    // Pipeline registers: all stages advance together, or all hold on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (in_ready) begin
            v_q   <= stage_v;
            a_q   <= stage_a;
            b_q   <= stage_b;
            s_q   <= s_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
// Reference model works on whole integers; a queue holds expected results in order.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    cla_pipe_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc    = 0;
    bit          lat_chk = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [18:0] prev_out;
    logic [17:0] exp_q[$];
    int          acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Whole-number reference: returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        int unsigned ux;
        int unsigned uy;
        int unsigned ur;
        int          sx;
        int          sy;
        int          sr;
        logic        co;
        logic        ov;
        logic [15:0] r;
        ux = x;
        uy = y;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + (ci ? 1 : 0);
            co = (ur > 32'hFFFF);
            sr = sx + sy + (ci ? 1 : 0);
        end
        ov = (sr > 32767) || (sr < -32768);
        r  = ur[15:0];
`ifdef CLA_SAT_EN
        if (ov) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {ov, co, r};
    endfunction

    // One clock cycle: check outputs, track accepts/emits, advance to next negedge.
    task automatic cycle();
        logic [17:0] e;
        int          t0;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (stalled_prev) begin
            chk("hold", {13'd0, out_valid, ovf, cout, sum}, {13'd0, prev_out});
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                t0 = acc_q.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
                chk("cout", {31'd0, cout}, {31'd0, e[16]});
                chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
                if (lat_chk) chk("latency", cyc - t0, 32'd4);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc_q.push_back(cyc);
        end
        prev_out     = {out_valid, ovf, cout, sum};
        stalled_prev = out_valid && !out_ready;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && exp_q.size() > 0; n++) cycle();
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic sb);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sub = sb;
        cycle();
        in_valid = 1'b0;
        drain();
    endtask

    logic [15:0] sa[6];
    logic [15:0] sbv[6];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single beats with latency checking.
        lat_chk = 1'b1;
        beat(16'h1234, 16'h4321, 1'b0, 1'b0);
        beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        beat(16'h0005, 16'h0007, 1'b1, 1'b1);
        beat(16'h0007, 16'h0005, 1'b0, 1'b1);
        beat(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        beat(16'h8000, 16'h0001, 1'b0, 1'b1);
        beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        lat_chk = 1'b0;

        // Six back-to-back beats with a 3-cycle consumer stall mid-stream.
        for (int i = 0; i < 6; i++) begin
            sa[i]  = 16'($urandom());
            sbv[i] = 16'($urandom());
        end
        begin
            int i;
            i = 0;
            for (int t = 0; t < 40 && i < 6; t++) begin
                in_valid  = 1'b1;
                a         = sa[i];
                b         = sbv[i];
                cin       = t[0];
                sub       = t[1];
                out_ready = !(t >= 5 && t < 8);
                #1;
                if (t == 5) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (in_ready) i++;
                cycle();
            end
            chk("stream_all_accepted", i, 32'd6);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random traffic with random back-pressure.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = 16'($urandom());
            b   = 16'($urandom());
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Three beats in flight, first one at the output and held, then async reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sub = 1'b0;
        cin = 1'b0;
        a = 16'h1111; b = 16'h2222; cycle();
        a = 16'h3333; b = 16'h4444; cycle();
        a = 16'h5555; b = 16'h0101; cycle();
        in_valid = 1'b0;
        cycle();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'd0, sum}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        stalled_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
            cycle();
        end
        lat_chk = 1'b1;
        beat(16'h0001, 16'h0001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
